vga_scanout_param: RTL and testbench

//  Parametrised single-clock video scan-out engine: programmable-resolution timing generator plus packed-pixel fetch from a FWFT FIFO.

---
 rtl/vga_scanout_param.sv | 155 +++++++++++++++
 tb/tb_vga_scanout_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_param.sv
`timescale 1ns/1ps
// vga_scanout_param: parametrised pixel-clock timing generator with packed-pixel fetch from a FWFT FIFO.
// Optional XOR test pattern (input testpat_sel) is built only when VGA_SCANOUT_TESTPAT_EN is defined.
module vga_scanout_param #(
  parameter int               RES_X        = 640,
  parameter int               HFP          = 16,
  parameter int               HSYNC        = 96,
  parameter int               HBP          = 48,
  parameter int               RES_Y        = 480,
  parameter int               VFP          = 10,
  parameter int               VSYNC        = 2,
  parameter int               VBP          = 33,
  parameter logic             HSYNC_POL    = 1'b0,
  parameter logic             VSYNC_POL    = 1'b0,
  parameter int               DATA_W       = 8,
  parameter int               BPP          = 1,
  parameter int               REPEAT_X     = 1,
  parameter logic [BPP-1:0]   UNDERRUN_PIX = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_valid,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic              testpat_sel,
`endif
  output logic              fifo_rd,
  output logic              fifo_flush,
  output logic [BPP-1:0]    pixel,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic [15:0]       underrun_cnt
);

  localparam int FX        = RES_X + HFP + HSYNC + HBP;
  localparam int FY        = RES_Y + VFP + VSYNC + VBP;
  localparam int PPW       = DATA_W / BPP;
  localparam int WORD_CLKS = PPW * REPEAT_X;
  localparam int PH_W      = (WORD_CLKS > 1) ? $clog2(WORD_CLKS) : 1;

  localparam logic [11:0]     CX_LAST  = 12'(FX - 1);
  localparam logic [11:0]     CY_LAST  = 12'(FY - 1);
  localparam logic [11:0]     VIS_X    = 12'(RES_X);
  localparam logic [11:0]     VIS_Y    = 12'(RES_Y);
  localparam logic [11:0]     HS_START = 12'(RES_X + HFP);
  localparam logic [11:0]     HS_END   = 12'(RES_X + HFP + HSYNC);
  localparam logic [11:0]     VS_START = 12'(RES_Y + VFP);
  localparam logic [11:0]     VS_END   = 12'(RES_Y + VFP + VSYNC);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(WORD_CLKS - 1);

  logic [11:0]       cx;
  logic [11:0]       cy;
  logic [PH_W-1:0]   ph;       // clock position inside the current packed word
  logic              vis;
  logic              wb;
  logic              step;
  logic              hs_act;
  logic              vs_act;

  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_n;
  logic              under;
  logic              under_n;
  logic [BPP-1:0]    pixel_n;
  logic [15:0]       ucnt_n;

  assign vis    = (cx < VIS_X) && (cy < VIS_Y);
  assign wb     = vis && (ph == '0);
  assign step   = (REPEAT_X == 1) || !ph[0];
  assign hs_act = (cx >= HS_START) && (cx < HS_END);
  assign vs_act = (cy >= VS_START) && (cy < VS_END);

  // Gated by rst_n so the FIFO is never popped while the engine is held in reset at (0,0).
  assign fifo_rd = rst_n && wb && fifo_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
      ph <= '0;
    end else if (cx == CX_LAST) begin
      cx <= '0;
      ph <= '0;
      cy <= (cy == CY_LAST) ? 12'd0 : cy + 12'd1;
    end else begin
      cx <= cx + 12'd1;
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic [7:0] tp_val;
  assign tp_val = cx[7:0] ^ cy[7:0];
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shift_n = shift;
    under_n = under;
    pixel_n = '0;
    ucnt_n  = underrun_cnt;
    if (wb) begin
      if (fifo_valid) begin
        shift_n = fifo_data >> BPP;
        under_n = 1'b0;
        pixel_n = fifo_data[BPP-1:0];
      end else begin
        under_n = 1'b1;
        pixel_n = UNDERRUN_PIX;
        if (underrun_cnt != 16'hFFFF) ucnt_n = underrun_cnt + 16'd1;
      end
    end else if (vis) begin
      if (under) begin
        pixel_n = UNDERRUN_PIX;
      end else if (step) begin
        pixel_n = shift[BPP-1:0];
        shift_n = shift >> BPP;
      end else begin
        pixel_n = pixel;
      end
    end
`ifdef VGA_SCANOUT_TESTPAT_EN
    // Pattern only replaces the displayed value; fetch and underrun accounting keep running.
    if (vis && testpat_sel) pixel_n = tp_val[BPP-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift        <= '0;
      under        <= 1'b0;
      pixel        <= '0;
      de           <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      fifo_flush   <= 1'b0;
      frame_start  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      shift        <= shift_n;
      under        <= under_n;
      pixel        <= pixel_n;
      de           <= vis;
      hsync        <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync        <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      fifo_flush   <= (cy >= VIS_Y);
      frame_start  <= (cx == '0) && (cy == '0);
      underrun_cnt <= ucnt_n;
    end
  end

endmodule

// File: tb/tb_vga_scanout_param.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_scanout_param: randomized FIFO traffic against a frame-arithmetic model,
// plus a large-geometry instance driven dry to exercise underrun counter saturation.
module tb_vga_scanout_param;

  localparam int RX = 8, HF = 2, HS = 2, HB = 2;
  localparam int RY = 4, VF = 1, VS = 1, VB = 1;
  localparam int FX = RX + HF + HS + HB;      // 14
  localparam int FY = RY + VF + VS + VB;      // 7
  localparam int PPW = 4;                     // 8-bit words, 2 bits per pixel
  localparam logic [1:0] UP_A = 2'd3;
  localparam logic [1:0] UP_B = 2'd1;
  localparam int CX_W = 1024 + 12;            // line length of the saturation instance

  typedef struct {
    logic [1:0]  pix;
    logic        de, hs, vs, fl, fs;
    logic [15:0] uc;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    bit         under;
    int         uc;
  } ms_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_c = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t = 0;
  int mode = 0;
  bit sat_done = 0;

  logic [7:0]  data_a = 8'hE4, data_b = 8'hE4;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        tp_a = 1'b0;
  logic        rd_a, fl_a, de_a, hs_a, vs_a, fs_a;
  logic        rd_b, fl_b, de_b, hs_b, vs_b, fs_b;
  logic [1:0]  pix_a, pix_b;
  logic [15:0] uc_a, uc_b;

  logic [7:0]  data_c = 8'h00;
  logic        valid_c = 1'b0;
  logic        rd_c, fl_c, de_c, hs_c, vs_c, fs_c;
  logic [7:0]  pix_c;
  logic [15:0] uc_c;

  exp_t q_a[$];
  exp_t q_b[$];
  ms_t  ms_a, ms_b;
  bit   pend_a = 0, pend_b = 0;

  vga_scanout_param #(
    .RES_X(RX), .HFP(HF), .HSYNC(HS), .HBP(HB),
    .RES_Y(RY), .VFP(VF), .VSYNC(VS), .VBP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .DATA_W(8), .BPP(2), .REPEAT_X(1), .UNDERRUN_PIX(UP_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_data(data_a), .fifo_valid(valid_a),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .testpat_sel(tp_a),
`endif
    .fifo_rd(rd_a), .fifo_flush(fl_a), .pixel(pix_a), .de(de_a),
    .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .underrun_cnt(uc_a)
  );

  vga_scanout_param #(
    .RES_X(RX), .HFP(HF), .HSYNC(HS), .HBP(HB),
    .RES_Y(RY), .VFP(VF), .VSYNC(VS), .VBP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .DATA_W(8), .BPP(2), .REPEAT_X(2), .UNDERRUN_PIX(UP_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_data(data_b), .fifo_valid(valid_b),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .testpat_sel(1'b0),
`endif
    .fifo_rd(rd_b), .fifo_flush(fl_b), .pixel(pix_b), .de(de_b),
    .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b), .underrun_cnt(uc_b)
  );

  vga_scanout_param #(
    .RES_X(1024), .HFP(4), .HSYNC(4), .HBP(4),
    .RES_Y(128), .VFP(1), .VSYNC(1), .VBP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .DATA_W(8), .BPP(8), .REPEAT_X(1), .UNDERRUN_PIX(8'h00)
  ) dut_c (
    .clk(clk), .rst_n(rst_n_c), .fifo_data(data_c), .fifo_valid(valid_c),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .testpat_sel(1'b0),
`endif
    .fifo_rd(rd_c), .fifo_flush(fl_c), .pixel(pix_c), .de(de_c),
    .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c), .underrun_cnt(uc_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d, time=%0t)", name, act, exp, t, $time);
    end
  endtask

  // Reference: position from elapsed ticks, pixels from the word captured at each word start.
  function automatic void model(input int tt, input int rep, input logic [1:0] upix, input bit tp,
                                input bit valid, input logic [7:0] data, input ms_t si,
                                output ms_t so, output exp_t e, output bit rd);
    int cx  = tt % FX;
    int cy  = (tt / FX) % FY;
    bit vis = (cx < RX) && (cy < RY);
    int sub = cx % (PPW * rep);
    int k   = sub / rep;
    so = si;
    rd = 0;
    e.de  = vis;
    e.hs  = !((cx >= RX + HF) && (cx < RX + HF + HS));
    e.vs  = !((cy >= RY + VF) && (cy < RY + VF + VS));
    e.fl  = (cy >= RY);
    e.fs  = (cx == 0) && (cy == 0);
    e.pix = 2'd0;
    if (vis) begin
      if (sub == 0) begin
        if (valid) begin
          so.word  = data;
          so.under = 0;
          rd       = 1;
        end else begin
          so.under = 1;
          if (so.uc < 65535) so.uc = so.uc + 1;
        end
      end
      if (tp)            e.pix = 2'((cx ^ cy) & 3);
      else if (so.under) e.pix = upix;
      else               e.pix = 2'((int'(so.word) >> (2 * k)) & 3);
    end
    e.uc = 16'(so.uc);
  endfunction

  task automatic run_cycles(input int n);
    exp_t ea, eb;
    ms_t  na, nb;
    bit   ra, rb;
    int   cx, cy;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cx = t % FX;
      cy = (t / FX) % FY;
      if (pend_a) data_a = (mode == 2) ? 8'($urandom) : 8'hE4;
      if (pend_b) data_b = (mode == 2) ? 8'($urandom) : 8'hE4;
      case (mode)
        0:       begin valid_a = 1'b1; valid_b = 1'b1; end
        1:       begin valid_a = !((cx == 4) && (cy == 0)); valid_b = 1'b1; end
        default: begin valid_a = ($urandom_range(0, 3) != 0); valid_b = ($urandom_range(0, 2) != 0); end
      endcase
`ifdef VGA_SCANOUT_TESTPAT_EN
      if (t % (FX * FY) == 0) tp_a = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
      #1;
      model(t, 1, UP_A, tp_a, valid_a, data_a, ms_a, na, ea, ra);
      model(t, 2, UP_B, 1'b0, valid_b, data_b, ms_b, nb, eb, rb);
      ms_a = na;
      ms_b = nb;
      check("fifo_rd_a", 32'(rd_a), 32'(ra));
      check("fifo_rd_b", 32'(rd_b), 32'(rb));
      q_a.push_back(ea);
      q_b.push_back(eb);
      pend_a = ra;
      pend_b = rb;
      t++;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_pixel_a", 32'(pix_a), 0);  check("rst_de_a", 32'(de_a), 0);
    check("rst_hsync_a", 32'(hs_a), 1);   check("rst_vsync_a", 32'(vs_a), 1);
    check("rst_flush_a", 32'(fl_a), 0);   check("rst_fs_a", 32'(fs_a), 0);
    check("rst_ucnt_a", 32'(uc_a), 0);    check("rst_rd_a", 32'(rd_a), 0);
    check("rst_pixel_b", 32'(pix_b), 0);  check("rst_de_b", 32'(de_b), 0);
    check("rst_ucnt_b", 32'(uc_b), 0);    check("rst_rd_b", 32'(rd_b), 0);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    valid_a = 1'b1;
    valid_b = 1'b1;
    #1;
    check_reset_vals();
    repeat (hold) @(posedge clk);
    #2;
    check_reset_vals();
    #1;
    rst_n  = 1'b1;
    t      = 0;
    ms_a   = '{word: 8'h00, under: 0, uc: 0};
    ms_b   = '{word: 8'h00, under: 0, uc: 0};
    pend_a = 0;
    pend_b = 0;
  endtask

  // Monitor: registered outputs for a pushed tick are compared after the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("pixel_a", 32'(pix_a), 32'(e.pix));
        check("de_a",    32'(de_a),  32'(e.de));
        check("hsync_a", 32'(hs_a),  32'(e.hs));
        check("vsync_a", 32'(vs_a),  32'(e.vs));
        check("flush_a", 32'(fl_a),  32'(e.fl));
        check("fstart_a", 32'(fs_a), 32'(e.fs));
        check("ucnt_a",  32'(uc_a),  32'(e.uc));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("pixel_b", 32'(pix_b), 32'(e.pix));
        check("de_b",    32'(de_b),  32'(e.de));
        check("hsync_b", 32'(hs_b),  32'(e.hs));
        check("fstart_b", 32'(fs_b), 32'(e.fs));
        check("ucnt_b",  32'(uc_b),  32'(e.uc));
      end
    end
  end

  // Dry FIFO on a wide raster: every visible clock is a missed word (one pixel per word).
  function automatic int words_c(input int c);
    int w = (c / CX_W) * 1024 + (((c % CX_W) < 1024) ? (c % CX_W) : 1024);
    return (w > 65535) ? 65535 : w;
  endfunction

  initial begin
    #3 rst_n_c = 1'b1;
    repeat (30000) @(posedge clk);
    #2;
    check("sat_ucnt_30000", 32'(uc_c), 32'(words_c(30000)));
    check("sat_rd_c", 32'(rd_c), 0);
    repeat (36000) @(posedge clk);
    #2;
    check("sat_ucnt_66000", 32'(uc_c), 32'(words_c(66000)));
    repeat (2000) @(posedge clk);
    #2;
    check("sat_ucnt_68000", 32'(uc_c), 32'hFFFF);
    sat_done = 1;
  end

  initial begin
    do_reset(2);
    mode = 0; run_cycles(2 * FX * FY);
    mode = 1; run_cycles(FX * FY);
    mode = 2; run_cycles(10 * FX * FY);
    // 33 more ticks leave the counters at (5,2) when reset hits mid-line.
    run_cycles(2 * FX + 5);
    do_reset(3);
    run_cycles(3 * FX * FY);
    @(posedge clk);
    #3;
    for (int i = 0; i < 80000 && !sat_done; i++) @(posedge clk);
    check("sat_finished", 32'(sat_done), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
